// File: rtl/id_reg_file_mp_pkg.sv
// Shared widths, the zero-register index and the scoreboard action encoding
// used by the decode-stage register file.
package id_reg_file_mp_pkg;

  localparam int COMMON_WIDTH = 32;
  localparam int REG_ADDR_W   = 5;
  localparam int REG_ZERO     = 0;

  // Next-state action for one busy bit, listed from highest to lowest priority.
  typedef enum logic [1:0] {
    BUSY_FLUSH = 2'd0,
    BUSY_SET   = 2'd1,
    BUSY_CLR   = 2'd2,
    BUSY_HOLD  = 2'd3
  } busy_op_e;

endpackage

// File: rtl/id_reg_busy.sv
// Pending-write scoreboard: one busy bit per register, set on issue, cleared by
// write-back or flush, with write-back clearing the read-side flag early.
module id_reg_busy
  import id_reg_file_mp_pkg::*;
#(
  parameter int ADDR_W = REG_ADDR_W,
  parameter int NREAD  = 2,
  parameter int NWRITE = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREAD*ADDR_W-1:0]  rd_addr,
  input  logic [NWRITE-1:0]        wr_en,
  input  logic [NWRITE*ADDR_W-1:0] wr_addr,
  input  logic                     issue_en,
  input  logic [ADDR_W-1:0]        issue_addr,
  input  logic                     flush,
  output logic [NREAD-1:0]         rd_busy
);

  localparam int NREG = 1 << ADDR_W;

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic [NREG-1:0] clr_hit;
  busy_op_e        busy_op [NREG];

  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      clr_hit[r] = 1'b0;
      for (int k = 0; k < NWRITE; k++) begin
        if (wr_en[k] && (wr_addr[k*ADDR_W +: ADDR_W] == ADDR_W'(r))) begin
          clr_hit[r] = 1'b1;
        end
      end
    end
  end

  // A new issue supersedes a same-cycle write-back from the previous producer.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      busy_op[r] = BUSY_HOLD;
      if (flush) begin
        busy_op[r] = BUSY_FLUSH;
      end else if (issue_en && (issue_addr == ADDR_W'(r)) && (r != REG_ZERO)) begin
        busy_op[r] = BUSY_SET;
      end else if (clr_hit[r]) begin
        busy_op[r] = BUSY_CLR;
      end
    end
  end

  always_comb begin
    busy_d = busy_q;
    for (int r = 0; r < NREG; r++) begin
      case (busy_op[r])
        BUSY_FLUSH: busy_d[r] = 1'b0;
        BUSY_SET:   busy_d[r] = 1'b1;
        BUSY_CLR:   busy_d[r] = 1'b0;
        default:    busy_d[r] = busy_q[r];
      endcase
    end
    busy_d[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  for (genvar gi = 0; gi < NREAD; gi++) begin : g_rd_busy
    logic [ADDR_W-1:0] ra;
    assign ra = rd_addr[gi*ADDR_W +: ADDR_W];
    assign rd_busy[gi] = (ra != ADDR_W'(REG_ZERO)) && busy_q[ra] && !clr_hit[ra];
  end

endmodule

// File: rtl/id_reg_file_mp.sv
// Multi-port decode-stage register file: prioritised write-back ports,
// same-cycle write-to-read bypass and a pending-write scoreboard.
module id_reg_file_mp
  import id_reg_file_mp_pkg::*;
#(
  parameter int DATA_W = COMMON_WIDTH,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int NREAD  = 2,
  parameter int NWRITE = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREAD*ADDR_W-1:0]  rd_addr,
  output logic [NREAD*DATA_W-1:0]  rd_data,
  output logic [NREAD-1:0]         rd_busy,
  input  logic [NWRITE-1:0]        wr_en,
  input  logic [NWRITE*ADDR_W-1:0] wr_addr,
  input  logic [NWRITE*DATA_W-1:0] wr_data,
  input  logic                     issue_en,
  input  logic [ADDR_W-1:0]        issue_addr,
  input  logic                     flush
);

  localparam int NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q  [NREG];
  logic [NREG-1:0]   wr_hit;
  logic [DATA_W-1:0] wr_win  [NREG];

  // Scanning ports upward lets the highest-index enabled port win.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      wr_hit[r] = 1'b0;
      wr_win[r] = '0;
      for (int k = 0; k < NWRITE; k++) begin
        if (wr_en[k] && (wr_addr[k*ADDR_W +: ADDR_W] == ADDR_W'(r))) begin
          wr_hit[r] = 1'b1;
          wr_win[r] = wr_data[k*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        regs_q[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if ((r != REG_ZERO) && wr_hit[r]) begin
          regs_q[r] <= wr_win[r];
        end
      end
    end
  end

  for (genvar gi = 0; gi < NREAD; gi++) begin : g_rd_port
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd_val;

    assign ra = rd_addr[gi*ADDR_W +: ADDR_W];

    always_comb begin
      rd_val = regs_q[ra];
      if (ra == ADDR_W'(REG_ZERO)) begin
        rd_val = '0;
      end else if (wr_hit[ra]) begin
        rd_val = wr_win[ra];
      end
    end

    assign rd_data[gi*DATA_W +: DATA_W] = rd_val;
  end

  id_reg_busy #(
    .ADDR_W (ADDR_W),
    .NREAD  (NREAD),
    .NWRITE (NWRITE)
  ) u_busy (
    .clk        (clk),
    .rst        (rst),
    .rd_addr    (rd_addr),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .issue_en   (issue_en),
    .issue_addr (issue_addr),
    .flush      (flush),
    .rd_busy    (rd_busy)
  );

endmodule

// File: tb/tb_id_reg_file_mp.sv
// Directed table, reset-mid-operation sequence and randomized traffic for
// id_reg_file_mp, all checked against an array-based reference model.
module tb_id_reg_file_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int NW = 2;
  localparam int NREG = 1 << AW;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NR*AW-1:0]  rd_addr = '0;
  logic [NR*DW-1:0]  rd_data;
  logic [NR-1:0]     rd_busy;
  logic [NW-1:0]     wr_en = '0;
  logic [NW*AW-1:0]  wr_addr = '0;
  logic [NW*DW-1:0]  wr_data = '0;
  logic              issue_en = 1'b0;
  logic [AW-1:0]     issue_addr = '0;
  logic              flush = 1'b0;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] mem  [NREG];
  logic          busy [NREG];

  always #5 clk = ~clk;

  id_reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NREAD(NR), .NWRITE(NW)) dut (
    .clk        (clk),
    .rst        (rst),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_busy    (rd_busy),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .issue_en   (issue_en),
    .issue_addr (issue_addr),
    .flush      (flush)
  );

  typedef struct {
    logic [1:0]  wen;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic        iss;
    logic [4:0]  ia;
    logic        fl;
    logic [4:0]  ra0, ra1;
    logic [31:0] ed0, ed1;
    logic [1:0]  eb;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] wen, input logic [4:0] wa0, input logic [4:0] wa1,
                       input logic [31:0] wd0, input logic [31:0] wd1, input logic iss,
                       input logic [4:0] ia, input logic fl, input logic [4:0] ra0,
                       input logic [4:0] ra1);
    wr_en      = wen;
    wr_addr    = {wa1, wa0};
    wr_data    = {wd1, wd0};
    issue_en   = iss;
    issue_addr = ia;
    flush      = fl;
    rd_addr    = {ra1, ra0};
  endtask

  function automatic logic [AW-1:0] waddr(input int p);
    return wr_addr[p*AW +: AW];
  endfunction

  function automatic logic written(input logic [AW-1:0] a);
    for (int p = 0; p < NW; p++) if (wr_en[p] && waddr(p) == a) return 1'b1;
    return 1'b0;
  endfunction

  // Expected read: the highest-numbered write port aimed at the address wins.
  function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
    if (a == 0) return '0;
    for (int p = NW - 1; p >= 0; p--) if (wr_en[p] && waddr(p) == a) return wr_data[p*DW +: DW];
    return mem[a];
  endfunction

  function automatic logic model_busy(input logic [AW-1:0] a);
    return (a != 0) && busy[a] && !written(a);
  endfunction

  task automatic model_reset();
    for (int r = 0; r < NREG; r++) begin
      mem[r]  = '0;
      busy[r] = 1'b0;
    end
  endtask

  task automatic model_clock();
    logic [DW-1:0] nmem  [NREG];
    logic          nbusy [NREG];
    for (int r = 1; r < NREG; r++) begin
      nmem[r]  = model_read(AW'(r));
      nbusy[r] = busy[r];
      if (written(AW'(r))) nbusy[r] = 1'b0;
      if (issue_en && issue_addr == AW'(r)) nbusy[r] = 1'b1;
      if (flush) nbusy[r] = 1'b0;
    end
    for (int r = 1; r < NREG; r++) begin
      mem[r]  = nmem[r];
      busy[r] = nbusy[r];
    end
  endtask

  // Called at a negedge with inputs applied: compare, clock, update the model.
  task automatic step(input string tag);
    logic [AW-1:0] a;
    #1;
    for (int k = 0; k < NR; k++) begin
      a = rd_addr[k*AW +: AW];
      chk($sformatf("%s.data%0d", tag, k), rd_data[k*DW +: DW], model_read(a));
      chk($sformatf("%s.busy%0d", tag, k), 32'(rd_busy[k]), 32'(model_busy(a)));
    end
    $display("%s wen=%b wa=%h wd=%h iss=%b ia=%0d fl=%b ra=%h rd=%h rb=%b",
             tag, wr_en, wr_addr, wr_data, issue_en, issue_addr, flush, rd_addr, rd_data, rd_busy);
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  function automatic vec_t mk(input logic [1:0] wen, input logic [4:0] wa0, input logic [4:0] wa1,
                              input logic [31:0] wd0, input logic [31:0] wd1, input logic iss,
                              input logic [4:0] ia, input logic fl, input logic [4:0] ra0,
                              input logic [4:0] ra1, input logic [31:0] ed0,
                              input logic [31:0] ed1, input logic [1:0] eb);
    vec_t v;
    v.wen = wen; v.wa0 = wa0; v.wa1 = wa1; v.wd0 = wd0; v.wd1 = wd1;
    v.iss = iss; v.ia = ia; v.fl = fl; v.ra0 = ra0; v.ra1 = ra1;
    v.ed0 = ed0; v.ed1 = ed1; v.eb = eb;
    return v;
  endfunction

  initial begin
    //               wen    wa0 wa1 wd0           wd1           iss ia fl ra0 ra1 ed0           ed1           eb
    vecs[0]  = mk(2'b01, 3,  0,  32'h12345678, 0,            0,  0, 0, 3,  0,  32'h12345678, 0,            2'b00);
    vecs[1]  = mk(2'b00, 0,  0,  0,            0,            0,  0, 0, 3,  7,  32'h12345678, 0,            2'b00);
    vecs[2]  = mk(2'b11, 7,  7,  32'h1111,     32'h2222,     0,  0, 0, 7,  3,  32'h2222,     32'h12345678, 2'b00);
    vecs[3]  = mk(2'b00, 0,  0,  0,            0,            0,  0, 0, 7,  0,  32'h2222,     0,            2'b00);
    vecs[4]  = mk(2'b11, 0,  0,  32'hFFFFFFFF, 32'hFFFFFFFF, 1,  0, 0, 0,  0,  0,            0,            2'b00);
    vecs[5]  = mk(2'b00, 0,  0,  0,            0,            0,  0, 0, 0,  0,  0,            0,            2'b00);
    vecs[6]  = mk(2'b00, 0,  0,  0,            0,            1,  9, 0, 9,  0,  0,            0,            2'b00);
    vecs[7]  = mk(2'b00, 0,  0,  0,            0,            0,  0, 0, 9,  9,  0,            0,            2'b11);
    vecs[8]  = mk(2'b10, 0,  9,  0,            32'hABCD,     0,  0, 0, 9,  0,  32'hABCD,     0,            2'b00);
    vecs[9]  = mk(2'b01, 9,  0,  32'h55,       0,            1,  9, 0, 9,  3,  32'h55,       32'h12345678, 2'b00);
    vecs[10] = mk(2'b00, 0,  0,  0,            0,            0,  0, 0, 9,  3,  32'h55,       32'h12345678, 2'b01);
    vecs[11] = mk(2'b00, 0,  0,  0,            0,            1,  4, 0, 4,  6,  0,            0,            2'b00);
    vecs[12] = mk(2'b00, 0,  0,  0,            0,            1,  6, 0, 4,  6,  0,            0,            2'b01);
    vecs[13] = mk(2'b00, 0,  0,  0,            0,            1,  8, 1, 4,  6,  0,            0,            2'b11);
    vecs[14] = mk(2'b00, 0,  0,  0,            0,            0,  0, 0, 8,  4,  0,            0,            2'b00);
    vecs[15] = mk(2'b00, 0,  0,  0,            0,            0,  0, 0, 6,  9,  0,            32'h55,       2'b00);

    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("reset.data", rd_data[31:0], 32'h0);
    chk("reset.busy", 32'(rd_busy), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].wen, vecs[i].wa0, vecs[i].wa1, vecs[i].wd0, vecs[i].wd1,
            vecs[i].iss, vecs[i].ia, vecs[i].fl, vecs[i].ra0, vecs[i].ra1);
      #1;
      chk($sformatf("vec%0d.d0", i), rd_data[31:0], vecs[i].ed0);
      chk($sformatf("vec%0d.d1", i), rd_data[63:32], vecs[i].ed1);
      chk($sformatf("vec%0d.busy", i), 32'(rd_busy), 32'(vecs[i].eb));
      #1;
      step($sformatf("vec%0d", i));
    end

    // Reset mid-operation: r5 written and issued, then reset with a write on the reset edge.
    drive(2'b01, 5, 0, 32'hDEADBEEF, 0, 1, 5, 0, 5, 3);
    step("rst.pre");
    drive(2'b00, 0, 0, 0, 0, 0, 0, 0, 5, 3);
    #1;
    chk("rst.pre.r5", rd_data[31:0], 32'hDEADBEEF);
    chk("rst.pre.busy", 32'(rd_busy), 32'h1);
    rst = 1'b1;
    #1;
    chk("rst.mid.r5", rd_data[31:0], 32'h0);
    chk("rst.mid.r3", rd_data[63:32], 32'h0);
    chk("rst.mid.busy", 32'(rd_busy), 32'h0);
    $display("rst.mid rd=%h rb=%b", rd_data, rd_busy);
    drive(2'b01, 5, 0, 32'h1234, 0, 1, 5, 0, 5, 3);
    @(posedge clk);
    @(negedge clk);
    drive(2'b00, 0, 0, 0, 0, 0, 0, 0, 5, 9);
    rst = 1'b0;
    model_reset();
    #1;
    chk("rst.post.r5", rd_data[31:0], 32'h0);
    chk("rst.post.r9", rd_data[63:32], 32'h0);
    chk("rst.post.busy", 32'(rd_busy), 32'h0);
    step("rst.post");

    for (int i = 0; i < 400; i++) begin
      logic [4:0] a [5];
      for (int j = 0; j < 5; j++) begin
        a[j] = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      end
      drive(2'($urandom), a[0], a[1], $urandom, $urandom, ($urandom_range(0, 2) == 0),
            a[2], ($urandom_range(0, 15) == 0), a[3], a[4]);
      step($sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
